sampro_response_checker: RTL and testbench
==========================================

// Module: sampro_response_checker
// PURPOSE
//  Synthesizable response checker for 3-input Boolean-function blocks (e.g. SamPro): the receiving end of the
//  stimulus sequence {a,b,c}=000..111 applied to a DUT. Watches the applied vector and the DUT output y.
//  After each new vector has been stable for SETTLE_CYCLES, it compares y to a parameterised truth table.
//  Tracks coverage of all 2^N_IN vectors, counts mismatches and reports pass/fail when coverage completes.
// PARAMETERS
//  N_IN          3      number of function inputs; vector index = {a,b,c}, a = MSB
//  TRUTH_TABLE   8'h00  expected y; bit i = expected output for vector value i (width 2**N_IN)
//  SETTLE_CYCLES 4      stable cycles required before sampling y (>=1)
//  CNT_W         8      width of err_count (saturating)
// PORTS
//  clk            in   1        single clock; all state updates on rising edge
//  reset          in   1        synchronous, active-high reset
//  start          in   1        1-cycle pulse: clear results and begin a check run
//  vec            in   N_IN     input vector applied to the DUT ({a,b,c})
//  y              in   1        DUT output under test
//  busy           out  1        run in progress (SETTLE or HOLD)
//  done           out  1        all vectors covered; held until next start/reset
//  pass           out  1        valid when done: 1 iff err_count==0
//  err_count      out  CNT_W    number of mismatching samples, saturates at all-ones
//  cov_mask       out  2**N_IN  bit i set once vector i has been sampled
//  fail_valid     out  1        a mismatch has been recorded this run
//  fail_vec       out  N_IN     vector of the FIRST mismatch (held)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, pass=0, err_count=0, cov_mask=0, fail_valid=0, fail_vec=0.
//  - FSM states: IDLE, SETTLE, HOLD, DONE.
//    IDLE:   wait for start. start -> clear err_count/cov_mask/fail_*; load prev_vec<=vec; stab_cnt<=0 -> SETTLE.
//    SETTLE: each cycle, if vec!=prev_vec: prev_vec<=vec, stab_cnt<=0 (restart). Else stab_cnt++.
//            When vec==prev_vec and stab_cnt==SETTLE_CYCLES-1: SAMPLE this cycle -> HOLD (or DONE, see below).
//    SAMPLE (single cycle, not a state): exp=TRUTH_TABLE[vec]; cov_mask[vec]<=1;
//            if y!=exp: err_count++ (saturating); if !fail_valid: fail_valid<=1, fail_vec<=vec.
//            If the updated cov_mask is all-ones -> DONE, else -> HOLD.
//    HOLD:   vector already checked; wait for vec!=prev_vec -> prev_vec<=vec, stab_cnt<=0 -> SETTLE.
//            A vector is never sampled twice consecutively; re-applying it after another vector re-checks it.
//    DONE:   done=1, pass=(err_count==0); outputs frozen; start -> cleared run as from IDLE.
//  - busy=1 in SETTLE and HOLD only. Sample latency: SETTLE_CYCLES cycles after the first cycle of a new vec.
//  - The sample is taken in the cycle that stab_cnt reaches SETTLE_CYCLES-1; result registers update at the
//    following edge.
//  - start while busy: restart run (clear all results, SETTLE on current vec). start has priority over a same-cycle
//    sample.
//  - reset mid-run: overrides everything, returns to reset values next edge.
//  - y may glitch during settling; only the value in the sample cycle matters.
//  - Vectors may arrive in any order or repeat; DONE requires every index covered at least once.
// STRUCTURE
//  - Package sampro_chk_pkg: typedef enum logic [1:0] {IDLE,SETTLE,HOLD,DONE} chk_state_t; localparam N_VEC=2**N_IN.
//  - One sub-module: stability_counter (vec change detect + stab_cnt, outputs stable_pulse). Compare/score logic inline.
// TESTING
//  - TRUTH_TABLE=8'b1001_0110, SETTLE=4; start; vec 0..7 ascending, each held 10 cycles, y=correct
//    -> done=1, pass=1, err_count=0, cov_mask=8'hFF.
//  - Same, but y forced 1 for vec=3'b010 -> err_count=1, fail_valid=1, fail_vec=3'b010, pass=0.
//  - vec held only 3 cycles at 3'b101 (SETTLE=4), then 3'b110 -> cov_mask[5]=0; no sample of 5; run not done.
//  - vec held 50 cycles at 3'b000 -> exactly one sample (cov_mask=8'h01, err_count unchanged after cycle 5).
//  - Mismatch on all 8 vectors with CNT_W=2 over 2 runs without start -> err_count saturates at 2'b11.
//  - reset asserted mid-run after 4 vectors -> next cycle all outputs 0, state IDLE; start restarts cleanly.

Source files
------------

// File: rtl/sampro_chk_pkg.sv
// Shared types and default sizing for the SamPro response checker.
package sampro_chk_pkg;

    localparam int unsigned N_IN_DEF = 3;
    localparam int unsigned N_VEC    = 2**N_IN_DEF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD,
        DONE
    } chk_state_t;

endpackage

// File: rtl/stability_counter.sv
// Tracks the last applied vector and counts how long it has stayed unchanged.
module stability_counter
    import sampro_chk_pkg::*;
#(
    parameter int unsigned N_IN          = N_IN_DEF,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [N_IN-1:0] vec_i,
    output logic            stable_pulse_c_o,
    output logic            vec_changed_c_o
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [N_IN-1:0]  prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    assign vec_changed_c_o  = (vec_i != prev_q);
    assign stable_pulse_c_o = en_i && !vec_changed_c_o && (cnt_q == CNT_LAST);

    // Any vector change restarts the count; the count parks at its last value once reached.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (load_i || vec_changed_c_o) begin
            prev_d = vec_i;
            cnt_d  = '0;
        end else if (en_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sampro_response_checker.sv
// Checks a 3-input Boolean block's output against a truth table once each applied vector settles,
// tracking coverage, mismatch count and the first failing vector.
module sampro_response_checker
    import sampro_chk_pkg::*;
#(
    parameter int unsigned          N_IN          = N_IN_DEF,
    parameter logic [(2**N_IN)-1:0] TRUTH_TABLE   = '0,
    parameter int unsigned          SETTLE_CYCLES = 4,
    parameter int unsigned          CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [N_IN-1:0]      vec_i,
    input  logic                 y_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CNT_W-1:0]     err_count_o,
    output logic [(2**N_IN)-1:0] cov_mask_o,
    output logic                 fail_valid_o,
    output logic [N_IN-1:0]      fail_vec_o
);

    localparam int unsigned VEC_CNT = 2**N_IN;

    chk_state_t         state_q, state_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [VEC_CNT-1:0] cov_q, cov_d;
    logic               fv_q, fv_d;
    logic [N_IN-1:0]    fvec_q, fvec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic load_c;
    logic stable_c;
    logic changed_c;
    logic exp_y_c;

    stability_counter #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_stab (
        .clk              (clk),
        .reset            (reset),
        .load_i           (load_c),
        .en_i             (state_q == SETTLE),
        .vec_i            (vec_i),
        .stable_pulse_c_o (stable_c),
        .vec_changed_c_o  (changed_c)
    );

    // Start wins over a same-cycle sample; a sample is a single cycle inside SETTLE.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cov_d   = cov_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        load_c  = 1'b0;
        exp_y_c = 1'b0;
        if (start_i) begin
            state_d = SETTLE;
            err_d   = '0;
            cov_d   = '0;
            fv_d    = 1'b0;
            fvec_d  = '0;
            load_c  = 1'b1;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (stable_c) begin
                        exp_y_c = TRUTH_TABLE[vec_i];
                        cov_d   = cov_q | (VEC_CNT'(1) << vec_i);
                        if (y_i != exp_y_c) begin
                            if (err_q != {CNT_W{1'b1}}) begin
                                err_d = err_q + CNT_W'(1);
                            end
                            if (!fv_q) begin
                                fv_d   = 1'b1;
                                fvec_d = vec_i;
                            end
                        end
                        state_d = (&cov_d) ? DONE : HOLD;
                    end
                end
                HOLD: begin
                    if (changed_c) begin
                        state_d = SETTLE;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == SETTLE) || (state_d == HOLD);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= '0;
            cov_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = err_q;
    assign cov_mask_o   = cov_q;
    assign fail_valid_o = fv_q;
    assign fail_vec_o   = fvec_q;

endmodule

// File: tb/tb_sampro_response_checker.sv
// Scoreboard bench for sampro_response_checker (odd-parity truth table, 4-cycle settle).
module tb_sampro_response_checker;
    import sampro_chk_pkg::*;

    localparam int unsigned S = 4;
    localparam logic [7:0] TT = 8'b1001_0110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       y = 1'b0;
    logic [2:0] vec = 3'd0;

    logic       busy, done, pass, fv;
    logic [7:0] err, cov;
    logic [2:0] fvec;
    logic       s_busy, s_done, s_pass, s_fv;
    logic [1:0] s_err;
    logic [7:0] s_cov;
    logic [2:0] s_fvec;

    always #5 clk = ~clk;

    sampro_response_checker #(.N_IN(3), .TRUTH_TABLE(TT), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start_i(start), .vec_i(vec), .y_i(y),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err),
        .cov_mask_o(cov), .fail_valid_o(fv), .fail_vec_o(fvec));

    sampro_response_checker #(.N_IN(3), .TRUTH_TABLE(TT), .SETTLE_CYCLES(S), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start_i(start), .vec_i(vec), .y_i(y),
        .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_count_o(s_err),
        .cov_mask_o(s_cov), .fail_valid_o(s_fv), .fail_vec_o(s_fvec));

    typedef struct {
        logic [2:0] v;
        logic [7:0] cov;
        logic [7:0] err;
        logic [1:0] err_sat;
        logic       fv;
        logic [2:0] fvec;
        logic       done;
        logic       pass;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [7:0] m_cov;
    int         m_err;
    logic [1:0] m_err_sat;
    logic       m_fv, m_done, m_started;
    logic [2:0] m_fvec, m_last;

    function automatic logic golden(input logic [2:0] v);
        return ^v;
    endfunction

    task automatic model_clear();
        m_cov = '0; m_err = 0; m_err_sat = '0; m_fv = 1'b0; m_fvec = '0; m_done = 1'b0;
    endtask

    // Drive one vector for 'hold' cycles (optionally with start), predict, then drain the scoreboard.
    task automatic apply_vec(input string tag, input logic [2:0] v, input logic yv,
                             input int hold, input bit st);
        exp_t e;
        if (st) begin
            model_clear();
            m_started = 1'b1;
        end
        if (m_started && !m_done && hold >= int'(S) + 1 && (st || v != m_last)) begin
            m_cov[v] = 1'b1;
            if (yv !== golden(v)) begin
                if (m_err < 255) m_err++;
                if (m_err_sat != 2'b11) m_err_sat++;
                if (!m_fv) begin
                    m_fv = 1'b1;
                    m_fvec = v;
                end
            end
            if (m_cov == 8'hFF) m_done = 1'b1;
        end
        m_last = v;
        e.v = v; e.cov = m_cov; e.err = 8'(m_err); e.err_sat = m_err_sat;
        e.fv = m_fv; e.fvec = m_fvec; e.done = m_done;
        e.pass = m_done && (m_err == 0);
        e.busy = m_started && !m_done;
        sb.push_back(e);

        vec = v; y = yv; start = st;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (hold - 1) begin
            @(posedge clk); #1;
        end

        e = sb.pop_front();
        checks++; if (cov !== e.cov) begin failures++;
            $display("FAIL %s v=%0d cov_mask got %h exp %h", tag, e.v, cov, e.cov); end
        checks++; if (err !== e.err) begin failures++;
            $display("FAIL %s v=%0d err_count got %0d exp %0d", tag, e.v, err, e.err); end
        checks++; if (s_err !== e.err_sat) begin failures++;
            $display("FAIL %s v=%0d err_count_sat got %0d exp %0d", tag, e.v, s_err, e.err_sat); end
        checks++; if (fv !== e.fv) begin failures++;
            $display("FAIL %s v=%0d fail_valid got %b exp %b", tag, e.v, fv, e.fv); end
        checks++; if (fvec !== e.fvec) begin failures++;
            $display("FAIL %s v=%0d fail_vec got %0d exp %0d", tag, e.v, fvec, e.fvec); end
        checks++; if (done !== e.done) begin failures++;
            $display("FAIL %s v=%0d done got %b exp %b", tag, e.v, done, e.done); end
        checks++; if (pass !== e.pass) begin failures++;
            $display("FAIL %s v=%0d pass got %b exp %b", tag, e.v, pass, e.pass); end
        checks++; if (busy !== e.busy) begin failures++;
            $display("FAIL %s v=%0d busy got %b exp %b", tag, e.v, busy, e.busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done got %b exp 0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset pass got %b exp 0", pass); end
        checks++; if (err !== 8'd0) begin failures++; $display("FAIL reset err_count got %0d exp 0", err); end
        checks++; if (cov !== 8'h00) begin failures++; $display("FAIL reset cov_mask got %h exp 00", cov); end
        checks++; if (fv !== 1'b0) begin failures++; $display("FAIL reset fail_valid got %b exp 0", fv); end
        checks++; if (fvec !== 3'd0) begin failures++; $display("FAIL reset fail_vec got %0d exp 0", fvec); end
        checks++; if (s_err !== 2'd0) begin failures++; $display("FAIL reset err_sat got %0d exp 0", s_err); end
        reset = 1'b0;
        model_clear();
        m_started = 1'b0;
        m_last = 3'd0;
    endtask

    task automatic test_full_pass();
        for (int i = 0; i < 8; i++)
            apply_vec("full_pass", 3'(i), golden(3'(i)), 10, i == 0);
    endtask

    task automatic test_single_error();
        for (int i = 0; i < 8; i++)
            apply_vec("single_err", 3'(i), (i == 2) ? ~golden(3'(i)) : golden(3'(i)), 10, i == 0);
    endtask

    task automatic test_short_hold();
        apply_vec("short_hold", 3'd0, golden(3'd0), 10, 1'b1);
        apply_vec("short_hold", 3'd5, golden(3'd5), 3, 1'b0);
        apply_vec("short_hold", 3'd6, golden(3'd6), 10, 1'b0);
        apply_vec("short_hold", 3'd5, golden(3'd5), 4, 1'b0);
        apply_vec("short_hold", 3'd7, golden(3'd7), 5, 1'b0);
    endtask

    task automatic test_long_hold();
        apply_vec("long_hold", 3'd0, golden(3'd0), 10, 1'b1);
        apply_vec("long_hold", 3'd0, ~golden(3'd0), 40, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++)
            apply_vec("saturate", 3'(i), ~golden(3'(i)), 8, i == 0);
        for (int i = 0; i < 8; i++)
            apply_vec("frozen", 3'(i), ~golden(3'(i)), 8, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 4; i++)
            apply_vec("pre_reset", 3'(i), ~golden(3'(i)), 10, i == 0);
        test_reset();
        apply_vec("idle_no_start", 3'd3, golden(3'd3), 10, 1'b0);
        for (int i = 0; i < 8; i++)
            apply_vec("post_reset", 3'(7 - i), golden(3'(7 - i)), 7, i == 0);
    endtask

    task automatic test_start_while_busy();
        for (int i = 0; i < 3; i++)
            apply_vec("busy_pre", 3'(i), ~golden(3'(i)), 10, i == 0);
        for (int i = 0; i < 8; i++)
            apply_vec("restart", 3'((i + 5) % 8), golden(3'((i + 5) % 8)), 6, i == 0);
    endtask

    task automatic test_back_to_back();
        logic [2:0] v;
        logic       yv;
        v = 3'($urandom_range(0, 7));
        apply_vec("random", v, golden(v), 6, 1'b1);
        for (int n = 0; n < 80 && !m_done; n++) begin
            do v = 3'($urandom_range(0, 7)); while (v == m_last);
            yv = ($urandom_range(0, 3) == 0) ? ~golden(v) : golden(v);
            apply_vec("random", v, yv, int'($urandom_range(3, 8)), 1'b0);
        end
        checks++; if (done !== 1'b1) begin failures++;
            $display("FAIL random_done done got %b exp 1", done); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_pass();
        test_single_error();
        test_short_hold();
        test_long_hold();
        test_saturation();
        test_reset_mid_run();
        test_start_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
